// File: rtl/bsg_manycore_ruche_link_tieoff_monitor.sv
// Edge tie-off for ruche links: drives polarity-correct idle values outward and
// counts errant inbound packets per channel, capturing the first offender's header.
// Channel layout (MSB first): {fwd.v, fwd.ready_and_rev, fwd.data, rev.v, rev.ready_and_rev, rev.data}.
module bsg_manycore_ruche_link_tieoff_monitor #(
    parameter int addr_width_p     = 32,
    parameter int data_width_p     = 32,
    parameter int x_cord_width_p   = 7,
    parameter int y_cord_width_p   = 7,
    parameter int num_links_p      = 1,
    parameter int ruche_factor_X_p = 3,
    parameter int ruche_stage_p    = 0,
    parameter int west_not_east_p  = 0,
    parameter int sink_p           = 0,
    parameter int count_width_p    = 8,
    localparam int fwd_data_width_lp = addr_width_p + data_width_p + 2*x_cord_width_p + 2*y_cord_width_p,
    localparam int rev_data_width_lp = data_width_p + x_cord_width_p + y_cord_width_p,
    localparam int link_width_lp     = fwd_data_width_lp + rev_data_width_lp + 4,
    localparam int hdr_width_lp      = 2*x_cord_width_p + y_cord_width_p,
    localparam int chan_width_lp     = (num_links_p > 1) ? $clog2(num_links_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_links_p*link_width_lp-1:0]   ruche_link_i,
    output logic [num_links_p*link_width_lp-1:0]   ruche_link_o,
    input  logic                                   clear_i,
    output logic                                   error_o,
    output logic [num_links_p*count_width_p-1:0]   fwd_count_o,
    output logic [num_links_p*count_width_p-1:0]   rev_count_o,
    output logic                                   first_v_o,
    output logic [chan_width_lp-1:0]               first_chan_o,
    output logic                                   first_rev_o,
    output logic [hdr_width_lp-1:0]                first_hdr_o
);

    localparam logic stage_odd_lp   = (ruche_stage_p % 2) == 1;
    localparam logic factor_even_lp = (ruche_factor_X_p % 2) == 0;
    localparam logic west_lp        = west_not_east_p != 0;
    localparam logic sink_lp        = sink_p != 0;

    // Outgoing and incoming wires alternate polarity per stage; with an odd factor the two edges differ.
    localparam logic inv_out_lp = (ruche_stage_p > 0)
        && (factor_even_lp ? stage_odd_lp : (west_lp ? !stage_odd_lp : stage_odd_lp));
    localparam logic inv_in_lp  = (ruche_stage_p > 0)
        && (factor_even_lp ? stage_odd_lp : (west_lp ? stage_odd_lp : !stage_odd_lp));

    localparam logic [link_width_lp-1:0] idle_chan_lp =
        {1'b0, sink_lp, {fwd_data_width_lp{1'b0}}, 1'b0, sink_lp, {rev_data_width_lp{1'b0}}};

    assign ruche_link_o = {num_links_p{idle_chan_lp}} ^ {(num_links_p*link_width_lp){inv_out_lp}};

    logic [num_links_p*link_width_lp-1:0]         link_in_s;
    logic [num_links_p-1:0]                       fwd_v_s;
    logic [num_links_p-1:0]                       rev_v_s;
    logic [num_links_p-1:0][hdr_width_lp-1:0]     fwd_hdr_s;
    logic [num_links_p-1:0][x_cord_width_p-1:0]   rev_dx_s;
    logic [num_links_p-1:0]                       fwd_v_r;
    logic [num_links_p-1:0]                       rev_v_r;
    logic [num_links_p-1:0]                       fwd_ev_s;
    logic [num_links_p-1:0]                       rev_ev_s;
    logic [num_links_p-1:0]                       hit_s;

    assign link_in_s = ruche_link_i ^ {(num_links_p*link_width_lp){inv_in_lp}};

    for (genvar c = 0; c < num_links_p; c++) begin : g_chan
        assign fwd_v_s[c]   = link_in_s[c*link_width_lp + link_width_lp - 1];
        assign rev_v_s[c]   = link_in_s[c*link_width_lp + rev_data_width_lp + 1];
        assign fwd_hdr_s[c] = link_in_s[c*link_width_lp + rev_data_width_lp + 2 +: hdr_width_lp];
        assign rev_dx_s[c]  = link_in_s[c*link_width_lp +: x_cord_width_p];
    end

    // A stalled sender holds valid, so without sink only the rising edge is a new packet.
    assign fwd_ev_s = sink_lp ? fwd_v_s : (fwd_v_s & ~fwd_v_r);
    assign rev_ev_s = sink_lp ? rev_v_s : (rev_v_s & ~rev_v_r);
    assign hit_s    = fwd_ev_s | rev_ev_s;

    logic                       win_v_s;
    logic [chan_width_lp-1:0]   win_chan_s;
    logic                       win_rev_s;
    logic [hdr_width_lp-1:0]    win_hdr_s;

    // Pick the lowest channel with an event; forward beats reverse within a channel.
    always_comb begin
        win_v_s    = 1'b0;
        win_chan_s = '0;
        win_rev_s  = 1'b0;
        win_hdr_s  = '0;
        for (int c = num_links_p - 1; c >= 0; c--) begin
            win_v_s    = win_v_s | hit_s[c];
            win_chan_s = hit_s[c] ? chan_width_lp'(c) : win_chan_s;
            win_rev_s  = hit_s[c] ? !fwd_ev_s[c] : win_rev_s;
            win_hdr_s  = hit_s[c] ? (fwd_ev_s[c] ? fwd_hdr_s[c] : hdr_width_lp'(rev_dx_s[c])) : win_hdr_s;
        end
    end

    // Previous logical valids; tracked through clear so a held packet is not recounted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fwd_v_r <= '0;
            rev_v_r <= '0;
        end else begin
            fwd_v_r <= fwd_v_s;
            rev_v_r <= rev_v_s;
        end
    end

    logic [num_links_p-1:0][count_width_p-1:0] fwd_cnt_r;
    logic [num_links_p-1:0][count_width_p-1:0] rev_cnt_r;
    logic                                      error_r;
    logic                                      first_v_r;
    logic [chan_width_lp-1:0]                  first_chan_r;
    logic                                      first_rev_r;
    logic [hdr_width_lp-1:0]                   first_hdr_r;

    // Monitor state: saturating counters, sticky flag and first-error capture; clear wins over events.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fwd_cnt_r    <= '0;
            rev_cnt_r    <= '0;
            error_r      <= 1'b0;
            first_v_r    <= 1'b0;
            first_chan_r <= '0;
            first_rev_r  <= 1'b0;
            first_hdr_r  <= '0;
        end else if (clear_i) begin
            fwd_cnt_r    <= '0;
            rev_cnt_r    <= '0;
            error_r      <= 1'b0;
            first_v_r    <= 1'b0;
            first_chan_r <= '0;
            first_rev_r  <= 1'b0;
            first_hdr_r  <= '0;
        end else begin
            for (int c = 0; c < num_links_p; c++) begin
                if (fwd_ev_s[c] && (fwd_cnt_r[c] != {count_width_p{1'b1}})) begin
                    fwd_cnt_r[c] <= fwd_cnt_r[c] + count_width_p'(1);
                end else begin
                    fwd_cnt_r[c] <= fwd_cnt_r[c];
                end
                if (rev_ev_s[c] && (rev_cnt_r[c] != {count_width_p{1'b1}})) begin
                    rev_cnt_r[c] <= rev_cnt_r[c] + count_width_p'(1);
                end else begin
                    rev_cnt_r[c] <= rev_cnt_r[c];
                end
            end
            error_r <= error_r | win_v_s;
            if (win_v_s && !first_v_r) begin
                first_v_r    <= 1'b1;
                first_chan_r <= win_chan_s;
                first_rev_r  <= win_rev_s;
                first_hdr_r  <= win_hdr_s;
            end else begin
                first_v_r    <= first_v_r;
                first_chan_r <= first_chan_r;
                first_rev_r  <= first_rev_r;
                first_hdr_r  <= first_hdr_r;
            end
        end
    end

    assign fwd_count_o  = fwd_cnt_r;
    assign rev_count_o  = rev_cnt_r;
    assign error_o      = error_r;
    assign first_v_o    = first_v_r;
    assign first_chan_o = first_chan_r;
    assign first_rev_o  = first_rev_r;
    assign first_hdr_o  = first_hdr_r;

`ifdef BSG_RUCHE_TIEOFF_REPORT
    // Define BSG_RUCHE_TIEOFF_REPORT to print every errant event.
    always @(posedge clk_i) begin
        for (int c = 0; c < num_links_p; c++) begin
            if (reset_n_i && fwd_ev_s[c]) begin
                $error("[BSG_ERROR] ruche tieoff chan %0d fwd src_x=%0d dest_y=%0d dest_x=%0d", c,
                       fwd_hdr_s[c][x_cord_width_p+y_cord_width_p +: x_cord_width_p],
                       fwd_hdr_s[c][x_cord_width_p +: y_cord_width_p],
                       fwd_hdr_s[c][x_cord_width_p-1:0]);
            end
            if (reset_n_i && rev_ev_s[c]) begin
                $error("[BSG_ERROR] ruche tieoff chan %0d rev dest_x=%0d", c, rev_dx_s[c]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_ruche_link_tieoff_monitor.sv
// Bench for the ruche tie-off monitor: three instances (east odd-factor stage 1, stage 0,
// west even-factor sink) checked by directed scenarios and a randomized model comparison.
module tb_bsg_manycore_ruche_link_tieoff_monitor;

    localparam int AW = 4, DW = 4, XW = 3, YW = 3, NL = 2;
    localparam int FW = AW + DW + 2*XW + 2*YW;
    localparam int RW = DW + XW + YW;
    localparam int LW = FW + RW + 4;
    localparam int HW = 2*XW + YW;
    localparam int CWA = 8, CWC = 4;

    localparam int FACT [3] = '{3, 3, 2};
    localparam int STG  [3] = '{1, 0, 3};
    localparam int WEST [3] = '{0, 0, 1};
    localparam int SINK [3] = '{0, 0, 1};
    localparam int CW   [3] = '{8, 8, 4};

    logic clk;
    logic rst_n;
    logic [2:0] clr;
    logic [LW-1:0] lin [3][NL];
    logic [NL*LW-1:0] in_p [3];
    logic [NL*LW-1:0] out_p [3];
    logic [2:0] err, fv, frev, fch;
    logic [HW-1:0] fhdr [3];
    logic [NL*CWA-1:0] fc_a, rc_a, fc_b, rc_b;
    logic [NL*CWC-1:0] fc_c, rc_c;
    bit inv_in [3];
    bit inv_out [3];

    int errors = 0;
    int checks = 0;

    bit m_prev [3][NL][2];
    int m_cnt [3][NL][2];
    bit m_err [3], m_fv [3], m_frev [3];
    int m_fch [3];
    logic [HW-1:0] m_fhdr [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_in
        assign in_p[g] = {lin[g][1], lin[g][0]} ^ {(NL*LW){inv_in[g]}};
    end

    bsg_manycore_ruche_link_tieoff_monitor #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .num_links_p(NL), .ruche_factor_X_p(3), .ruche_stage_p(1), .west_not_east_p(0),
        .sink_p(0), .count_width_p(CWA)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .ruche_link_i(in_p[0]), .ruche_link_o(out_p[0]),
        .clear_i(clr[0]), .error_o(err[0]), .fwd_count_o(fc_a), .rev_count_o(rc_a),
        .first_v_o(fv[0]), .first_chan_o(fch[0]), .first_rev_o(frev[0]), .first_hdr_o(fhdr[0])
    );

    bsg_manycore_ruche_link_tieoff_monitor #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .num_links_p(NL), .ruche_factor_X_p(3), .ruche_stage_p(0), .west_not_east_p(0),
        .sink_p(0), .count_width_p(CWA)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .ruche_link_i(in_p[1]), .ruche_link_o(out_p[1]),
        .clear_i(clr[1]), .error_o(err[1]), .fwd_count_o(fc_b), .rev_count_o(rc_b),
        .first_v_o(fv[1]), .first_chan_o(fch[1]), .first_rev_o(frev[1]), .first_hdr_o(fhdr[1])
    );

    bsg_manycore_ruche_link_tieoff_monitor #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .num_links_p(NL), .ruche_factor_X_p(2), .ruche_stage_p(3), .west_not_east_p(1),
        .sink_p(1), .count_width_p(CWC)
    ) dut_c (
        .clk_i(clk), .reset_n_i(rst_n), .ruche_link_i(in_p[2]), .ruche_link_o(out_p[2]),
        .clear_i(clr[2]), .error_o(err[2]), .fwd_count_o(fc_c), .rev_count_o(rc_c),
        .first_v_o(fv[2]), .first_chan_o(fch[2]), .first_rev_o(frev[2]), .first_hdr_o(fhdr[2])
    );

    function automatic bit polarity(int factor, int stage, int west, bit outward);
        bit odd;
        odd = (stage % 2) == 1;
        if (stage == 0) return 1'b0;
        if ((factor % 2) == 0) return odd;
        if (outward) return (west != 0) ? !odd : odd;
        return (west != 0) ? odd : !odd;
    endfunction

    function automatic logic [NL*LW-1:0] exp_out(int d);
        logic [LW-1:0] ch;
        ch = '0;
        ch[LW-2] = (SINK[d] != 0);
        ch[RW]   = (SINK[d] != 0);
        return {ch, ch} ^ {(NL*LW){inv_out[d]}};
    endfunction

    function automatic int o_cnt(int d, int c, int dir);
        case (d)
            0: return (dir == 1) ? int'(rc_a[c*CWA +: CWA]) : int'(fc_a[c*CWA +: CWA]);
            1: return (dir == 1) ? int'(rc_b[c*CWA +: CWA]) : int'(fc_b[c*CWA +: CWA]);
            default: return (dir == 1) ? int'(rc_c[c*CWC +: CWC]) : int'(fc_c[c*CWC +: CWC]);
        endcase
    endfunction

    function automatic bit lvalid(int d, int c, int dir);
        return (dir == 0) ? lin[d][c][LW-1] : lin[d][c][RW+1];
    endfunction

    task automatic model_zero(int d, bit with_prev);
        for (int c = 0; c < NL; c++) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[d][c][k] = 0;
                if (with_prev) m_prev[d][c][k] = 1'b0;
            end
        end
        m_err[d] = 1'b0; m_fv[d] = 1'b0; m_frev[d] = 1'b0; m_fch[d] = 0; m_fhdr[d] = '0;
    endtask

    // Reference behaviour for one clock edge, from the event/priority/clear rules.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            bit ev [NL][2];
            for (int c = 0; c < NL; c++)
                for (int k = 0; k < 2; k++)
                    ev[c][k] = (SINK[d] != 0) ? lvalid(d, c, k) : (lvalid(d, c, k) && !m_prev[d][c][k]);
            if (clr[d]) begin
                model_zero(d, 1'b0);
            end else begin
                for (int c = 0; c < NL; c++) begin
                    for (int k = 0; k < 2; k++) begin
                        if (ev[c][k]) begin
                            if (m_cnt[d][c][k] < (1 << CW[d]) - 1) m_cnt[d][c][k]++;
                            m_err[d] = 1'b1;
                            if (!m_fv[d]) begin
                                m_fv[d] = 1'b1;
                                m_fch[d] = c;
                                m_frev[d] = (k == 1);
                                m_fhdr[d] = (k == 0) ? lin[d][c][RW+2 +: HW] : HW'(lin[d][c][XW-1:0]);
                            end
                        end
                    end
                end
            end
            for (int c = 0; c < NL; c++)
                for (int k = 0; k < 2; k++)
                    m_prev[d][c][k] = lvalid(d, c, k);
        end
    endtask

    task automatic step();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(int d, int c, bit v, logic [HW-1:0] hdr);
        lin[d][c][LW-1] = v;
        lin[d][c][RW+2 +: HW] = hdr;
    endtask

    task automatic set_rev(int d, int c, bit v, logic [XW-1:0] dx);
        lin[d][c][RW+1] = v;
        lin[d][c][XW-1:0] = dx;
    endtask

    task automatic clear_dut(int d);
        clr[d] = 1'b1;
        step();
        clr[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 3'b000;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < NL; c++) lin[d][c] = '0;
            model_zero(d, 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({err[d], fv[d], frev[d], fch[d]} !== 4'b0000 || fhdr[d] !== '0) begin
                errors++;
                $display("FAIL reset_flags d=%0d: got err=%b fv=%b rev=%b ch=%b hdr=%h, want all 0",
                         d, err[d], fv[d], frev[d], fch[d], fhdr[d]);
            end
            for (int c = 0; c < NL; c++) begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (o_cnt(d, c, k) != 0) begin
                        errors++;
                        $display("FAIL reset_count d=%0d c=%0d dir=%0d: got %0d want 0", d, c, k, o_cnt(d, c, k));
                    end
                end
            end
            checks++;
            if (out_p[d] !== exp_out(d)) begin
                errors++;
                $display("FAIL reset_link_o d=%0d: got %h want %h", d, out_p[d], exp_out(d));
            end
        end
        checks++;
        if (out_p[0] !== {(NL*LW){1'b1}} || out_p[1] !== {(NL*LW){1'b0}}) begin
            errors++;
            $display("FAIL tieoff_polarity: got a=%h b=%h want all ones / all zeros", out_p[0], out_p[1]);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 100; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (err[d] !== 1'b0 || o_cnt(d, 0, 0) != 0 || o_cnt(d, 0, 1) != 0 ||
                    o_cnt(d, 1, 0) != 0 || o_cnt(d, 1, 1) != 0 || out_p[d] !== exp_out(d)) begin
                    errors++;
                    $display("FAIL idle d=%0d cyc=%0d: got err=%b link=%h want err=0 counts=0 link=%h",
                             d, i, err[d], out_p[d], exp_out(d));
                end
            end
        end
    endtask

    task automatic test_sink_count();
        logic [HW-1:0] hdr;
        hdr = HW'($urandom);
        set_fwd(2, 1, 1'b1, hdr);
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (o_cnt(2, 1, 0) != ((i + 1 < 15) ? i + 1 : 15)) begin
                errors++;
                $display("FAIL sink_count cyc=%0d: got %0d want %0d", i, o_cnt(2, 1, 0), (i + 1 < 15) ? i + 1 : 15);
            end
        end
        checks++;
        if (o_cnt(2, 0, 0) != 0 || o_cnt(2, 0, 1) != 0 || err[2] !== 1'b1) begin
            errors++;
            $display("FAIL sink_other: got ch0 f=%0d r=%0d err=%b want 0 0 1", o_cnt(2, 0, 0), o_cnt(2, 0, 1), err[2]);
        end
        checks++;
        if (fv[2] !== 1'b1 || fch[2] !== 1'b1 || frev[2] !== 1'b0 || fhdr[2] !== hdr) begin
            errors++;
            $display("FAIL sink_capture: got v=%b ch=%b rev=%b hdr=%h want 1 1 0 %h", fv[2], fch[2], frev[2], fhdr[2], hdr);
        end
        set_fwd(2, 1, 1'b0, '0);
        step();
    endtask

    task automatic test_stall_edge();
        clear_dut(0);
        set_rev(0, 0, 1'b1, 3'd5);
        repeat (10) step();
        set_rev(0, 0, 1'b0, 3'd5);
        step();
        set_rev(0, 0, 1'b1, 3'd5);
        repeat (5) step();
        checks++;
        if (o_cnt(0, 0, 1) != 2) begin
            errors++;
            $display("FAIL stall_rev_count: got %0d want 2", o_cnt(0, 0, 1));
        end
        checks++;
        if (fv[0] !== 1'b1 || frev[0] !== 1'b1 || fch[0] !== 1'b0 || fhdr[0] !== 9'd5 || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_capture: got v=%b rev=%b ch=%b hdr=%h err=%b want 1 1 0 005 1",
                     fv[0], frev[0], fch[0], fhdr[0], err[0]);
        end
        set_rev(0, 0, 1'b0, '0);
        step();
    endtask

    task automatic test_first_priority();
        clear_dut(0);
        set_fwd(0, 1, 1'b1, {3'd3, 3'd5, 3'd7});
        set_rev(0, 0, 1'b1, 3'd2);
        step();
        checks++;
        if (fv[0] !== 1'b1 || fch[0] !== 1'b0 || frev[0] !== 1'b1 || fhdr[0] !== 9'd2) begin
            errors++;
            $display("FAIL priority_same_cycle: got v=%b ch=%b rev=%b hdr=%h want 1 0 1 002", fv[0], fch[0], frev[0], fhdr[0]);
        end
        set_fwd(0, 1, 1'b0, '0);
        set_rev(0, 0, 1'b0, '0);
        step();
        set_fwd(0, 1, 1'b1, {3'd1, 3'd1, 3'd1});
        step();
        checks++;
        if (fch[0] !== 1'b0 || frev[0] !== 1'b1 || fhdr[0] !== 9'd2 || o_cnt(0, 1, 0) != 2) begin
            errors++;
            $display("FAIL priority_hold: got ch=%b rev=%b hdr=%h fcnt1=%0d want 0 1 002 2", fch[0], frev[0], fhdr[0], o_cnt(0, 1, 0));
        end
        set_fwd(0, 1, 1'b0, '0);
        step();
        clear_dut(0);
        set_fwd(0, 1, 1'b1, {3'd3, 3'd5, 3'd7});
        step();
        checks++;
        if (fch[0] !== 1'b1 || frev[0] !== 1'b0 || fhdr[0] !== 9'd239) begin
            errors++;
            $display("FAIL fwd_header: got ch=%b rev=%b hdr=%0d want 1 0 239", fch[0], frev[0], fhdr[0]);
        end
        set_fwd(0, 1, 1'b0, '0);
        step();
    endtask

    task automatic test_clear_collision();
        clear_dut(0);
        set_fwd(0, 0, 1'b1, 9'h1a5);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        checks++;
        if (o_cnt(0, 0, 0) != 0 || err[0] !== 1'b0 || fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_collision: got fcnt=%0d err=%b fv=%b want 0 0 0", o_cnt(0, 0, 0), err[0], fv[0]);
        end
        step();
        checks++;
        if (o_cnt(0, 0, 0) != 0 || err[0] !== 1'b0 || fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_recount: got fcnt=%0d err=%b fv=%b want 0 0 0", o_cnt(0, 0, 0), err[0], fv[0]);
        end
        set_fwd(0, 0, 1'b0, '0);
        step();
    endtask

    task automatic test_midrun_reset();
        set_rev(0, 1, 1'b1, 3'd4);
        step();
        step();
        checks++;
        if (o_cnt(0, 1, 1) != 1 || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: got rcnt1=%0d err=%b want 1 1", o_cnt(0, 1, 1), err[0]);
        end
        #2 rst_n = 1'b0;
        for (int d = 0; d < 3; d++) model_zero(d, 1'b1);
        #1;
        checks++;
        if (err[0] !== 1'b0 || fv[0] !== 1'b0 || fhdr[0] !== '0 || o_cnt(0, 1, 1) != 0 || o_cnt(0, 0, 1) != 0) begin
            errors++;
            $display("FAIL midrun_async_clear: got err=%b fv=%b hdr=%h rcnt1=%0d want all 0", err[0], fv[0], fhdr[0], o_cnt(0, 1, 1));
        end
        checks++;
        if (out_p[0] !== exp_out(0)) begin
            errors++;
            $display("FAIL midrun_link_o: got %h want %h", out_p[0], exp_out(0));
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (o_cnt(0, 1, 1) != 1 || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_recount: got rcnt1=%0d err=%b want 1 1", o_cnt(0, 1, 1), err[0]);
        end
        set_rev(0, 1, 1'b0, '0);
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < NL; c++) begin
                    lin[d][c] = LW'({$urandom, $urandom});
                    lin[d][c][LW-1] = ($urandom_range(0, 2) == 0);
                    lin[d][c][RW+1] = ($urandom_range(0, 2) == 0);
                end
                clr[d] = ($urandom_range(0, 39) == 0);
            end
            step();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (err[d] !== m_err[d] || fv[d] !== m_fv[d] || frev[d] !== m_frev[d] ||
                    int'(fch[d]) != m_fch[d] || fhdr[d] !== m_fhdr[d]) begin
                    errors++;
                    $display("FAIL rand_flags d=%0d cyc=%0d: got err=%b fv=%b rev=%b ch=%0d hdr=%h want %b %b %b %0d %h",
                             d, i, err[d], fv[d], frev[d], fch[d], fhdr[d], m_err[d], m_fv[d], m_frev[d], m_fch[d], m_fhdr[d]);
                end
                for (int c = 0; c < NL; c++) begin
                    for (int k = 0; k < 2; k++) begin
                        checks++;
                        if (o_cnt(d, c, k) != m_cnt[d][c][k]) begin
                            errors++;
                            $display("FAIL rand_count d=%0d c=%0d dir=%0d cyc=%0d: got %0d want %0d",
                                     d, c, k, i, o_cnt(d, c, k), m_cnt[d][c][k]);
                        end
                    end
                end
                checks++;
                if (out_p[d] !== exp_out(d)) begin
                    errors++;
                    $display("FAIL rand_link_o d=%0d: got %h want %h", d, out_p[d], exp_out(d));
                end
            end
        end
        clr = 3'b000;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            inv_in[d]  = polarity(FACT[d], STG[d], WEST[d], 1'b0);
            inv_out[d] = polarity(FACT[d], STG[d], WEST[d], 1'b1);
        end
        test_reset();
        test_idle();
        test_sink_count();
        test_stall_edge();
        test_first_priority();
        test_clear_collision();
        test_midrun_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bsg_manycore_ruche_link_tieoff_monitor.md
# bsg_manycore_ruche_link_tieoff_monitor

Multi-channel, polarity-aware tie-off for ruche links at the array edge. It drives idle, correctly polarised values onto the unused outgoing ruche links. It also watches the incoming links with synthesizable logic: it counts errant forward and reverse packets per channel, holds a sticky error flag, and captures the header of the first errant packet. Instances sit on the east and west edges of a pod, one per edge row, and replace the debug-only tieoff with state that software and tests can read.

## Interface
Parameters:
- addr_width_p, none: manycore packet address width.
- data_width_p, none: manycore packet data width.
- x_cord_width_p, none: x coordinate width.
- y_cord_width_p, none: y coordinate width.
- num_links_p, 1: number of ruche links tied off, one channel each.
- ruche_factor_X_p, none: ruche factor. Only its parity matters.
- ruche_stage_p, none: ruche stage at this edge.
- west_not_east_p, none: 1 for the west edge, 0 for the east edge.
- sink_p, 0: 1 asserts logical ready so errant beats are consumed; 0 withholds ready so senders stall.
- count_width_p, 8: width of each per-channel saturating counter.

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: reset, asynchronous, active-low.
- ruche_link_i, input, num_links_p*ruche_x_link_sif_width: incoming links. Channel c occupies slice c.
- ruche_link_o, output, num_links_p*ruche_x_link_sif_width: outgoing tie-off links.
- clear_i, input, 1: synchronous clear of all monitor state.
- error_o, output, 1: sticky flag, set by any errant event.
- fwd_count_o, output, num_links_p*count_width_p: errant forward events per channel.
- rev_count_o, output, num_links_p*count_width_p: errant reverse events per channel.
- first_v_o, output, 1: the first-error capture registers are valid.
- first_chan_o, output, `BSG_SAFE_CLOG2(num_links_p): channel of the first error.
- first_rev_o, output, 1: 0 means the first error was forward, 1 means reverse.
- first_hdr_o, output, 2*x_cord_width_p+y_cord_width_p: captured header fields.

## Operation
- Polarity, identical for all channels:
  - inv_out = (stage>0) & (factor even ? stage odd : (west ? stage even : stage odd)).
  - inv_in = (stage>0) & (factor even ? stage odd : (west ? stage odd : stage even)).
- Logical input of each channel = physical input XOR {width{inv_in}}.
- ruche_link_o, logical value per channel:
  - fwd.v=0, rev.v=0, all data=0.
  - fwd.ready_and_rev and rev.ready_and_rev equal sink_p.
  - The whole channel is then XOR {width{inv_out}}.
  - Purely parameter-driven, with no dependence on state or reset.
- Errant event on channel c, direction d (fwd or rev), with lv = logical d.v of channel c:
  - sink_p=1: one event per cycle with lv=1. Every beat is consumed.
  - sink_p=0: an event is a rising edge of lv, i.e. lv=1 and v_r[c][d]=0. A stalled, held packet counts once.
  - v_r registers lv every cycle, including cycles where clear_i=1.
- Counters: +1 per event, saturate at 2^count_width_p-1 with no wrap.
- error_o: set on any event and held until clear_i or reset.
- First-error capture, loaded only while first_v_o=0:
  - Winner among simultaneous events: lowest channel, forward before reverse within a channel.
  - Forward winner: first_hdr_o = {src_x, dest_y, dest_x} = fwd.data[0 +: 2*x+y].
  - Reverse winner: first_hdr_o = {zeros, dest_x}, with dest_x = rev.data[0 +: x].
  - Sets first_v_o.
- clear_i=1 zeroes the counters, error_o, first_v_o, first_chan_o, first_rev_o and first_hdr_o. Clear takes priority: events in the same cycle are dropped.
- In simulation only, each event also prints $error("[BSG_ERROR] ...") with the channel, direction and header fields.

## Timing
- Asynchronous reset (reset_n_i=0) sets all monitor registers and v_r to 0:
  - outputs: error_o=0, counts=0, first_v_o=0, first_chan_o=0, first_rev_o=0, first_hdr_o=0.
  - Monitor registers hold 0 while reset_n_i=0 and resume at the first posedge after deassertion.
- Latency: an event sampled at posedge N is visible on counters, error_o and first_* after posedge N, so one cycle of latency. There is no combinational input-to-monitor path.
- ruche_link_o is constant, including during reset.
- Reset asserted mid-stall with sink_p=0: v_r clears. If valid is still high after release, that is a new rising edge and counts again.

## Test plan
- Polarity and idle: ruche_factor_X_p=3, ruche_stage_p=1, west_not_east_p=0, sink_p=0, 2 channels, inputs held at logical idle.
  - ruche_link_o is all ones, counts stay 0, error_o=0 for 100 cycles.
  - Repeat with stage=0: ruche_link_o is all zeros.
- Sink counting: sink_p=1, count_width_p=4, channel 1 fwd.v high for 20 cycles.
  - fwd_count for channel 1 climbs to 15 and holds; channel 0 stays 0; error_o=1.
- Stall edge counting: sink_p=0, channel 0 rev.v held high for 10 cycles, dropped for 1 cycle, raised again.
  - rev_count for channel 0 = 2, first_rev_o=1.
- First-error priority:
  - Same cycle: channel 1 fwd with src_x=3, dest_y=5, dest_x=7, plus channel 0 rev with dest_x=2.
  - Required: first_chan_o=0, first_rev_o=1, first_hdr_o low bits=2.
  - A later channel 1 event leaves the capture unchanged.
- Clear collision: clear_i=1 in the same cycle as a channel 0 fwd event.
  - Next cycle: all counts 0, error_o=0, first_v_o=0.
  - With sink_p=0 and valid still high, there is no recount.
- Mid-run reset: pulse reset_n_i low asynchronously, off-edge, with counts nonzero.
  - All monitor outputs go to 0 immediately; ruche_link_o is unchanged.
